// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier, unsigned or two's-complement, start/ready/done handshake
module mul_iter #(
    parameter int WIDTH      = 24,
    parameter int RADIX_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 ready,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   out,
    output logic                 done
);

    localparam int N  = WIDTH / RADIX_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     mag2;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic                 neg;

    logic [WIDTH-1:0]     abs1;
    logic [WIDTH-1:0]     abs2;
    logic [2*WIDTH-1:0]   partial;

    // |most-negative| lands on 2^(WIDTH-1), which is representable as an unsigned magnitude
    always_comb begin
        abs1    = (signed_mode && in1[WIDTH-1]) ? -in1 : in1;
        abs2    = (signed_mode && in2[WIDTH-1]) ? -in2 : in2;
        partial = mcand * (2*WIDTH)'(mag2[RADIX_BITS-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            mag2  <= '0;
            mcand <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            out   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= {{WIDTH{1'b0}}, abs1};
                        mag2  <= abs2;
                        acc   <= '0;
                        count <= CW'(N - 1);
                        neg   <= signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        state <= CALC;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        acc   <= acc + partial;
                        mcand <= mcand << RADIX_BITS;
                        mag2  <= mag2 >> RADIX_BITS;
                        count <= count - CW'(1);
                        if (count == '0) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    // abort wins over completion so out keeps the previous result
                    if (!abort) begin
                        out  <= (neg && acc != '0) ? -acc : acc;
                        done <= 1'b1;
                    end
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// tb/tb_mul_iter.sv - scoreboard bench for mul_iter (WIDTH=24 R=2, plus WIDTH=32 R=1/2/4 sweep)
module tb_mul_iter;

    logic        clk;
    logic        rst_n;
    logic        start, abort, sm;
    logic [23:0] a, b;
    logic        ready, busy, done;
    logic [47:0] out;

    logic        s32, sm32;
    logic [31:0] a32, b32;
    logic        rdy32 [3];
    logic        bsy32 [3];
    logic        d32   [3];
    logic [63:0] o32   [3];
    logic        ab32;

    int vectors;
    int miscompares;
    logic [63:0] exp_q [$];

    mul_iter #(.WIDTH(24), .RADIX_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .signed_mode(sm),
        .in1(a), .in2(b), .ready(ready), .busy(busy), .out(out), .done(done)
    );

    mul_iter #(.WIDTH(32), .RADIX_BITS(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .start(s32), .abort(ab32), .signed_mode(sm32),
        .in1(a32), .in2(b32), .ready(rdy32[0]), .busy(bsy32[0]), .out(o32[0]), .done(d32[0])
    );
    mul_iter #(.WIDTH(32), .RADIX_BITS(2)) u_r2 (
        .clk(clk), .rst_n(rst_n), .start(s32), .abort(ab32), .signed_mode(sm32),
        .in1(a32), .in2(b32), .ready(rdy32[1]), .busy(bsy32[1]), .out(o32[1]), .done(d32[1])
    );
    mul_iter #(.WIDTH(32), .RADIX_BITS(4)) u_r4 (
        .clk(clk), .rst_n(rst_n), .start(s32), .abort(ab32), .signed_mode(sm32),
        .in1(a32), .in2(b32), .ready(rdy32[2]), .busy(bsy32[2]), .out(o32[2]), .done(d32[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                            input bit s, input int w);
        logic [63:0] hi, mask;
        hi = ~((64'd1 << w) - 64'd1);
        if (s && x[w-1]) x = x | hi;
        if (s && y[w-1]) y = y | hi;
        mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        return (x * y) & mask;
    endfunction

    // caller sits at a negedge; returns at the negedge after the accepting edge
    task automatic launch24(input logic [23:0] x, input logic [23:0] y, input logic s);
        a = x; b = y; sm = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 24'($urandom); b = 24'($urandom); sm = 1'($urandom);
    endtask

    task automatic wait_done24(input int from, output int e);
        for (e = from; e <= 60; e++) begin
            @(negedge clk);
            if (done) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (out !== 48'd0 || done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: out=%h done=%b busy=%b ready=%b, need 0/0/0/1", out, done, busy, ready);
        end
        vectors++;
        if (o32[2] !== 64'd0 || rdy32[0] !== 1'b1 || d32[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset32: out=%h ready=%b done=%b", o32[2], rdy32[0], d32[1]);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        int e;
        logic [63:0] x;
        exp_q.push_back(64'hFFFFFE000001);
        launch24(24'hFFFFFF, 24'hFFFFFF, 1'b0);
        vectors++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL unsigned_busy: ready=%b busy=%b, need 0/1", ready, busy);
        end
        wait_done24(1, e);
        x = exp_q.pop_front();
        vectors++;
        if (e !== 13 || out !== x[47:0] || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL unsigned_ff: edges=%0d out=%h ready=%b, need 13 %h 1", e, out, ready, x[47:0]);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || out !== x[47:0]) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b out=%h, need 0 %h", done, out, x[47:0]);
        end
    endtask

    task automatic test_signed;
        logic [23:0] ta [3] = '{24'hFFFFFF, 24'h800000, 24'h800000};
        logic [23:0] tb [3] = '{24'h000003, 24'h800000, 24'h000001};
        logic [47:0] te [3] = '{48'hFFFFFFFFFFFD, 48'h400000000000, 48'hFFFFFF800000};
        int e;
        logic [63:0] x;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({16'd0, te[i]});
            launch24(ta[i], tb[i], 1'b1);
            wait_done24(1, e);
            x = exp_q.pop_front();
            vectors++;
            if (e !== 13 || out !== x[47:0]) begin
                miscompares++;
                $display("FAIL signed_%0d: edges=%0d out=%h, need 13 %h", i, e, out, x[47:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int e;
        logic [63:0] x;
        exp_q.push_back(64'd35);
        launch24(24'd5, 24'd7, 1'b0);
        repeat (3) @(negedge clk);
        a = 24'd9; b = 24'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done24(5, e);
        x = exp_q.pop_front();
        vectors++;
        if (e !== 13 || out !== x[47:0]) begin
            miscompares++;
            $display("FAIL busy_start_drop: edges=%0d out=%0d, need 13 %0d", e, out, x);
        end
        exp_q.push_back(64'd81);
        launch24(24'd9, 24'd9, 1'b0);
        wait_done24(1, e);
        x = exp_q.pop_front();
        vectors++;
        if (e !== 13 || out !== x[47:0]) begin
            miscompares++;
            $display("FAIL start_in_done: edges=%0d out=%0d, need 13 %0d", e, out, x);
        end
    endtask

    task automatic test_abort;
        int e;
        int seen;
        logic [63:0] x;
        exp_q.push_back(64'd35);
        launch24(24'd5, 24'd7, 1'b0);
        wait_done24(1, e);
        x = exp_q.pop_front();
        @(negedge clk);
        launch24(24'd6, 24'd7, 1'b0);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || out !== x[47:0]) begin
            miscompares++;
            $display("FAIL abort_state: ready=%b busy=%b done=%b out=%0d, need 1/0/0/%0d",
                     ready, busy, done, out, x);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        vectors++;
        if (seen !== 0 || out !== 48'd35) begin
            miscompares++;
            $display("FAIL abort_nodone: pulses=%0d out=%0d, need 0 35", seen, out);
        end
        abort = 1'b1;
        exp_q.push_back(64'd6);
        launch24(24'd2, 24'd3, 1'b0);
        abort = 1'b0;
        wait_done24(1, e);
        x = exp_q.pop_front();
        vectors++;
        if (e !== 13 || out !== x[47:0]) begin
            miscompares++;
            $display("FAIL after_abort: edges=%0d out=%0d, need 13 %0d", e, out, x);
        end
    endtask

    task automatic test_reset_mid;
        int e;
        logic [63:0] x;
        launch24(24'hABCDEF, 24'h123456, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out !== 48'd0 || done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: out=%h done=%b busy=%b ready=%b, need 0/0/0/1", out, done, busy, ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(64'd0);
        launch24(24'd0, 24'h123456, 1'b0);
        wait_done24(1, e);
        x = exp_q.pop_front();
        vectors++;
        if (e !== 13 || out !== x[47:0]) begin
            miscompares++;
            $display("FAIL zero_op: edges=%0d out=%h, need 13 %h", e, out, x[47:0]);
        end
    endtask

    task automatic test_random24;
        int e;
        logic [23:0] x1, x2;
        logic [63:0] x;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1000; i++) begin
                x1 = 24'($urandom);
                x2 = 24'($urandom);
                if (i % 7 == 0) x1 = (i % 2) ? 24'h800000 : 24'h7FFFFF;
                if (i % 11 == 0) x2 = (i % 3 == 0) ? 24'hFFFFFF : 24'h800000;
                exp_q.push_back(ref_mul({40'd0, x1}, {40'd0, x2}, m[0], 24));
                launch24(x1, x2, m[0]);
                wait_done24(1, e);
                x = exp_q.pop_front();
                vectors++;
                if (e !== 13 || out !== x[47:0]) begin
                    miscompares++;
                    $display("FAIL rand24 m=%0d %h*%h: edges=%0d out=%h, need 13 %h",
                             m, x1, x2, e, out, x[47:0]);
                end
            end
        end
    endtask

    task automatic test_sweep32;
        int lat [3];
        int need [3] = '{33, 17, 9};
        logic [63:0] got [3];
        logic [63:0] x;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 100; i++) begin
                a32 = $urandom;
                b32 = $urandom;
                if (i == 0) begin a32 = 32'h80000000; b32 = 32'h80000000; end
                if (i == 1) begin a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF; end
                exp_q.push_back(ref_mul({32'd0, a32}, {32'd0, b32}, m[0], 32));
                sm32 = m[0];
                s32 = 1'b1;
                @(negedge clk);
                s32 = 1'b0;
                a32 = $urandom; b32 = $urandom;
                for (int k = 0; k < 3; k++) begin lat[k] = -1; got[k] = '0; end
                for (int e = 1; e <= 40; e++) begin
                    @(negedge clk);
                    for (int k = 0; k < 3; k++)
                        if (d32[k]) begin lat[k] = e; got[k] = o32[k]; end
                    if (lat[0] > 0 && lat[1] > 0 && lat[2] > 0) break;
                end
                x = exp_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    vectors++;
                    if (lat[k] !== need[k] || got[k] !== x) begin
                        miscompares++;
                        $display("FAIL sweep32 r%0d m=%0d: edges=%0d out=%h, need %0d %h",
                                 1 << k, m, lat[k], got[k], need[k], x);
                    end
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; sm = 1'b0; a = '0; b = '0;
        s32 = 1'b0; ab32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random24();
        test_sweep32();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
